// File: rtl/shift_add_responder.sv
// Datapath responder for the go/ack/en/done handshake: an unsigned shift-add
// multiply that runs one step per enabled cycle and raises ack when it is done.
module shift_add_responder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ack,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, REARM} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, REARM: begin
          if (go) begin
            mcand  <= {{WIDTH{1'b0}}, a_in};
            mplier <= b_in;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            ack    <= 1'b0;
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // en low is a stall: every register holds
          if (en) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST) begin
              result <= acc_nxt;
              busy   <= 1'b0;
              ack    <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          // a go still held from the previous launch must not relaunch
          if (!go) state <= REARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_responder.sv
// Directed bench for shift_add_responder: standalone jobs, stalls, held go,
// mid-job reset, and a run paired with a small go/en/done controller.
module tb_shift_add_responder;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           tgo, ten, integ;
  logic           go, en;
  logic [W-1:0]   a_in, b_in;
  logic           ack, busy;
  logic [2*W-1:0] result;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // controller: START -> COMPUTE -> FINISH -> RESTART -> COMPUTE ...
  typedef enum logic [1:0] {C_START, C_COMPUTE, C_FINISH, C_RESTART} cst_t;
  cst_t cst;
  logic ctl_go, ctl_en, done;

  always @(posedge clk or posedge rst) begin
    if (rst) cst <= C_START;
    else if (integ) begin
      case (cst)
        C_START:   cst <= C_COMPUTE;
        C_COMPUTE: if (ack) cst <= C_FINISH;
        C_FINISH:  cst <= C_RESTART;
        default:   cst <= C_COMPUTE;
      endcase
    end
  end

  assign ctl_go = integ && (cst == C_START || cst == C_RESTART);
  assign ctl_en = integ && (cst == C_COMPUTE) && !ack;
  assign done   = integ && (cst == C_FINISH);
  assign go     = integ ? ctl_go : tgo;
  assign en     = integ ? ctl_en : ten;

  shift_add_responder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go(go), .en(en), .a_in(a_in), .b_in(b_in),
    .ack(ack), .busy(busy), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One standalone job; mask bit n low-enables the n-th cycle after the load edge.
  task automatic job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [15:0] mask,
                     input int exp_lat, input logic [2*W-1:0] exp, input string tag);
    int n;
    tgo = 1'b0; ten = 1'b0;
    @(posedge clk); #1;
    a_in = a; b_in = b; tgo = 1'b1;
    @(posedge clk); #1;
    tgo = 1'b0;
    chk({tag, ".busy_load"}, busy, 1);
    chk({tag, ".ack_load"}, ack, 0);
    n = 0;
    while (!ack && n < 40) begin
      ten = (n < 16) ? !mask[n] : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ten = 1'b0;
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".result"}, result, exp);
    chk({tag, ".busy_done"}, busy, 0);
  endtask

  logic [W-1:0]   ia [3] = '{8'd3, 8'd200, 8'd17};
  logic [W-1:0]   ib [3] = '{8'd4, 8'd150, 8'd0};
  logic [2*W-1:0] ip [3] = '{16'd12, 16'd30000, 16'd0};

  initial begin
    int n, en_cnt, ovl;
    logic prev_ack;
    rst = 1'b1; tgo = 1'b0; ten = 1'b0; integ = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("rst.ack", ack, 0);
    chk("rst.busy", busy, 0);
    chk("rst.result", result, 0);
    rst = 1'b0;

    job(8'd13, 8'd11, 16'h0, W, 16'd143, "basic");

    // held go with new operands while in DONE; en high in the ack cycle too
    a_in = 8'd2; b_in = 8'd3; tgo = 1'b1; ten = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ten = 1'b0;
      chk("held.ack", ack, 1);
      chk("held.result", result, 143);
    end
    job(8'd2, 8'd3, 16'h0, W, 16'd6, "rearm");
    job(8'd255, 8'd255, 16'h0, W, 16'd65025, "max");
    job(8'd0, 8'd200, 16'h0, W, 16'd0, "zero");
    job(8'd6, 8'd7, 16'b10110, W + 3, 16'd42, "stall");

    // reset in the middle of 100*100
    tgo = 1'b0;
    @(posedge clk); #1;
    a_in = 8'd100; b_in = 8'd100; tgo = 1'b1;
    @(posedge clk); #1;
    tgo = 1'b0; ten = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst.busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    ten = 1'b0;
    chk("midrst.ack", ack, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.result", result, 0);
    @(negedge clk) rst = 1'b0;
    job(8'd5, 8'd5, 16'h0, W, 16'd25, "fresh");

    // integrated run with the controller
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    a_in = ia[0]; b_in = ib[0]; integ = 1'b1;
    ovl = 0;
    for (int j = 0; j < 3; j++) begin
      n = 0; en_cnt = 0; prev_ack = 1'b0;
      while (n < 60) begin
        @(negedge clk);
        n++;
        if (done) break;
        if (en) en_cnt++;
        if (en && ack) ovl++;
        prev_ack = ack;
      end
      chk($sformatf("integ%0d.done", j), done, 1);
      chk($sformatf("integ%0d.ack", j), ack, 1);
      chk($sformatf("integ%0d.ack_before_done", j), prev_ack, 1);
      chk($sformatf("integ%0d.en_cycles", j), en_cnt, W);
      chk($sformatf("integ%0d.result", j), result, ip[j]);
      if (j < 2) begin a_in = ia[j+1]; b_in = ib[j+1]; end
    end
    integ = 1'b0;
    chk("integ.en_ack_overlap", ovl, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
